raster_scanner: RTL and testbench

RASTER_SCANNER -- requirements
Module: raster_scanner

---
 rtl/mandel_pkg.sv | 10 +
 rtl/wrap_counter.sv | 26 ++
 rtl/raster_scanner.sv | 127 ++++++++++++
 tb/tb_raster_scanner.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_pkg.sv
// Shared types for the Mandelbrot pipeline: scan controller state encoding.
package mandel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear; at_max flags the terminal count.
module wrap_counter #(
    parameter int MAX = 1,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         at_max
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign at_max = (value == MAX_V);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
        end else if (inc) begin
            value <= at_max ? '0 : value + W'(1);
        end
    end

endmodule

// File: rtl/raster_scanner.sv
// Raster-order coordinate generator feeding the iteration engine, one pixel per handshake.
module raster_scanner
    import mandel_pkg::*;
#(
    parameter int H_PIX = 640,
    parameter int V_PIX = 480,
    parameter int FRM_W = 8,
    localparam int X_W   = $clog2(H_PIX),
    localparam int Y_W   = $clog2(V_PIX),
    localparam int IDX_W = $clog2(H_PIX * V_PIX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             continuous,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic [IDX_W-1:0] idx,
    output logic             eol,
    output logic             frame_done,
    output logic [FRM_W-1:0] frame_cnt,
    output logic             busy,
    output scan_state_t      state
);

    localparam logic [X_W-1:0] X_PENULT = X_W'(H_PIX - 2);

    // Handshake: a coordinate transfers on a rising edge where out_valid && out_ready;
    // while out_ready is low the presented coordinate and eol are held unchanged.
    logic hs;
    logic x_at_max;
    logic y_at_max;
    logic last_pix;

    assign hs       = out_valid && out_ready;
    assign last_pix = x_at_max && y_at_max;

    // Counters return to zero on their own after the last pixel, so they only
    // need an explicit clear on abort.
    wrap_counter #(
        .MAX (H_PIX - 1),
        .W   (X_W)
    ) u_x_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (abort),
        .inc    (hs),
        .value  (x),
        .at_max (x_at_max)
    );

    wrap_counter #(
        .MAX (V_PIX - 1),
        .W   (Y_W)
    ) u_y_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (abort),
        .inc    (x_at_max && hs),
        .value  (y),
        .at_max (y_at_max)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            idx        <= '0;
            eol        <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                idx       <= '0;
                eol       <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state     <= RUN;
                            out_valid <= 1'b1;
                            busy      <= 1'b1;
                            idx       <= '0;
                            eol       <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (hs) begin
                            if (last_pix) begin
                                frame_done <= 1'b1;
                                frame_cnt  <= frame_cnt + FRM_W'(1);
                                idx        <= '0;
                                eol        <= 1'b0;
                                if (!continuous) begin
                                    state     <= DONE;
                                    out_valid <= 1'b0;
                                    busy      <= 1'b0;
                                end
                            end else begin
                                idx <= idx + IDX_W'(1);
                                // Next x equals H_PIX-1 exactly when the current x is one short of it.
                                eol <= (x == X_PENULT);
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_raster_scanner.sv
// Directed bench for raster_scanner on a 4x3 raster with a 2-bit frame counter.
module tb_raster_scanner;
    import mandel_pkg::*;

    localparam int H_PIX = 4;
    localparam int V_PIX = 3;
    localparam int FRM_W = 2;
    localparam int X_W   = $clog2(H_PIX);
    localparam int Y_W   = $clog2(V_PIX);
    localparam int IDX_W = $clog2(H_PIX * V_PIX);
    localparam int BEAT_W = 1 + Y_W + X_W + IDX_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic             continuous;
    logic             out_ready;
    logic             out_valid;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [IDX_W-1:0] idx;
    logic             eol;
    logic             frame_done;
    logic [FRM_W-1:0] frame_cnt;
    logic             busy;
    scan_state_t      state;

    int checks   = 0;
    int failures = 0;
    int pulse_cnt;
    logic [FRM_W-1:0] exp_fc;
    logic [BEAT_W-1:0] exp_q[$];

    raster_scanner #(
        .H_PIX (H_PIX),
        .V_PIX (V_PIX),
        .FRM_W (FRM_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .continuous (continuous),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .x          (x),
        .y          (y),
        .idx        (idx),
        .eol        (eol),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .busy       (busy),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are observed and inputs changed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame();
        logic [X_W-1:0]   ex;
        logic [Y_W-1:0]   ey;
        logic [IDX_W-1:0] ei;
        logic             ee;
        for (int i = 0; i < H_PIX * V_PIX; i++) begin
            ex = X_W'(i % H_PIX);
            ey = Y_W'(i / H_PIX);
            ei = IDX_W'(i);
            ee = (i % H_PIX) == H_PIX - 1;
            exp_q.push_back({ee, ey, ex, ei});
        end
    endtask

    // Called at a sample point where the current coordinate is about to be accepted.
    task automatic beat_check(input string tag);
        logic [BEAT_W-1:0] e;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_beat"}, 32'({eol, y, x, idx}), 32'(e));
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, 32'(state), 32'(IDLE));
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_xyi"}, 32'({eol, y, x, idx}), 32'd0);
        chk({tag, "_fdone"}, 32'(frame_done), 32'd0);
        chk({tag, "_fcnt"}, 32'(frame_cnt), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0; out_ready = 1'b1;
        step();
        step();
        chk_reset("reset");
        rst = 1'b0;
        step();

        // Single frame, always ready.
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("sf_busy", 32'(busy), 32'd1);
        chk("sf_state", 32'(state), 32'(RUN));
        for (int b = 0; b < H_PIX * V_PIX; b++) begin
            chk("sf_fdone_low", 32'(frame_done), 32'd0);
            beat_check("sf");
            step();
        end
        chk("sf_fdone", 32'(frame_done), 32'd1);
        chk("sf_done_state", 32'(state), 32'(DONE));
        chk("sf_done_valid", 32'(out_valid), 32'd0);
        chk("sf_fcnt", 32'(frame_cnt), 32'd1);
        chk("sf_done_busy", 32'(busy), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("sf_idle_state", 32'(state), 32'(IDLE));
        chk("sf_fdone_pulse", 32'(frame_done), 32'd0);
        step();
        chk("sf_start_in_done_ignored", 32'(state), 32'(IDLE));
        chk("sf_sb_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure at idx 5.
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int b = 0; b < 5; b++) begin
            beat_check("bp_pre");
            step();
        end
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_xyi", 32'({eol, y, x, idx}), 32'({1'b0, 2'd1, 2'd1, 4'd5}));
        end
        out_ready = 1'b1;
        for (int b = 5; b < H_PIX * V_PIX; b++) begin
            beat_check("bp_post");
            step();
        end
        chk("bp_fcnt", 32'(frame_cnt), 32'd2);
        chk("bp_done_state", 32'(state), 32'(DONE));
        step();

        // Continuous scanning across five frames, counter wraps at 4.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset("rst2");
        continuous = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        pulse_cnt = 0;
        exp_fc = '0;
        for (int f = 0; f < 5; f++) begin
            push_frame();
            for (int b = 0; b < H_PIX * V_PIX; b++) begin
                if (frame_done) pulse_cnt++;
                if (b == 0 && f > 0) begin
                    exp_fc = exp_fc + FRM_W'(1);
                    chk("cont_fdone", 32'(frame_done), 32'd1);
                    chk("cont_fcnt", 32'(frame_cnt), 32'(exp_fc));
                end else begin
                    chk("cont_fdone_low", 32'(frame_done), 32'd0);
                end
                if (f == 4 && b == H_PIX * V_PIX - 1) continuous = 1'b0;
                beat_check("cont");
                step();
            end
        end
        if (frame_done) pulse_cnt++;
        chk("cont_pulses", 32'(pulse_cnt), 32'd5);
        chk("cont_last_fcnt", 32'(frame_cnt), 32'd1);
        chk("cont_done_state", 32'(state), 32'(DONE));
        chk("cont_done_valid", 32'(out_valid), 32'd0);
        step();

        // Abort at idx 6 with start asserted throughout the run.
        push_frame();
        start = 1'b1;
        step();
        for (int b = 0; b < 6; b++) begin
            beat_check("ab");
            step();
        end
        chk("ab_at_idx6", 32'(idx), 32'd6);
        abort = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        exp_q.delete();
        chk("ab_state", 32'(state), 32'(IDLE));
        chk("ab_valid", 32'(out_valid), 32'd0);
        chk("ab_xyi", 32'({eol, y, x, idx}), 32'd0);
        chk("ab_fcnt", 32'(frame_cnt), 32'd1);
        chk("ab_fdone", 32'(frame_done), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        step();

        // Reset mid-scan at idx 9 overrides start and handshake.
        push_frame();
        start = 1'b1;
        step();
        for (int b = 0; b < 9; b++) begin
            beat_check("rs");
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b0;
        exp_q.delete();
        chk_reset("rs_mid");

        // Abort coinciding with the last-pixel handshake.
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int b = 0; b < H_PIX * V_PIX - 1; b++) begin
            beat_check("al");
            step();
        end
        chk("al_at_last", 32'(idx), 32'd11);
        abort = 1'b1;
        step();
        abort = 1'b0;
        exp_q.delete();
        chk("al_fdone", 32'(frame_done), 32'd0);
        chk("al_fcnt", 32'(frame_cnt), 32'd0);
        chk("al_state", 32'(state), 32'(IDLE));
        chk("al_valid", 32'(out_valid), 32'd0);
        step();
        chk("al_fdone_after", 32'(frame_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
